seven_seg_scan_controller: RTL and testbench

- Time-multiplexes one shared 7-segment bus across NUM_DIGITS common-enable digits, sequencing digit slots with a prescaler and an anti-ghost blanking gap.
- Accepts a new multi-digit hex value over a valid/ready handshake and applies it only at frame boundaries, so no frame shows mixed old and new digits.
- Sits between the counter/state logic that produces display values and the board segment and digit-enable pins.

---
 rtl/seven_seg_scan_controller_if.sv | 23 ++
 rtl/seven_seg_scan_controller.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_controller_if.sv
// Load channel between a display-value producer and the 7-segment scan controller.
// One multi-digit hex word per valid/ready transfer; digit i lives in load_data[4i+3:4i].
interface seven_seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/seven_seg_scan_controller.sv
// Multiplexes one shared 7-segment bus over NUM_DIGITS digits, with a blanking gap at the
// start of each slot. New display values are double-buffered and swap in only at frame boundaries.
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  seven_seg_scan_controller_if.slave     load,
  input  logic [NUM_DIGITS-1:0]          blank_mask,
  output logic [6:0]                     seg,
  output logic [NUM_DIGITS-1:0]          dig_en,
  output logic [2:0]                     cur_digit,
  output logic                           frame_done
);

  localparam int                CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]        DIG_LAST   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Segment order {A,B,C,D,E,F,G}, A in the MSB.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              dig_q, dig_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    ready_q, ready_d;

  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_done_q, frame_done_d;

  logic [4*NUM_DIGITS-1:0] nib_sel;
  logic [NUM_DIGITS-1:0]   onehot;

  // Slot sequencing: cnt runs 0..SCAN_DIV-1 across BLANK then DRIVE of one digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        dig_d = '0;
        if (enable) state_d = BLANK;
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BLANK_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (dig_q == DIG_LAST) begin
            dig_d = '0;
            wrap  = 1'b1;
          end else begin
            dig_d = dig_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      dig_d   = '0;
      wrap    = 1'b0;
    end
  end

  // ready_q low means the pending buffer holds a word not yet applied.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    ready_d  = ready_q;
    if ((wrap || state_q == IDLE) && !ready_q) begin
      shadow_d = pend_q;
      ready_d  = 1'b1;
    end
    if (load.load_valid && ready_q) begin
      pend_d  = load.load_data;
      ready_d = 1'b0;
    end
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    nib_sel      = shadow_q >> {dig_d, 2'b00};
    onehot       = NUM_DIGITS'(1) << dig_d;
    seg_d        = '0;
    dig_en_d     = '0;
    frame_done_d = wrap;
    if (state_d == DRIVE) begin
      dig_en_d = onehot;
      if (~|(onehot & blank_mask)) seg_d = seg_decode(nib_sel[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dig_q        <= '0;
      shadow_q     <= '0;
      pend_q       <= '0;
      ready_q      <= 1'b1;
      seg_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      ready_q      <= ready_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg             = seg_q;
  assign dig_en          = dig_en_q;
  assign cur_digit       = dig_q;
  assign frame_done      = frame_done_q;
  assign load.load_ready = ready_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_controller;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [ND-1:0] blank_mask = '0;
  logic [6:0]    seg;
  logic [ND-1:0] dig_en;
  logic [2:0]    cur_digit;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seven_seg_scan_controller_if #(.NUM_DIGITS(ND)) lif ();

  seven_seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (lif.slave),
    .blank_mask(blank_mask),
    .seg       (seg),
    .dig_en    (dig_en),
    .cur_digit (cur_digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Checks one full frame (ND*SD cycles), starting with the first cycle after the call.
  // Optionally offers ld_val on load at frame cycle ld_at.
  task automatic run_frame(input logic [15:0] val, input logic [3:0] mask, input logic fd0,
                           input logic rdy0, input int ld_at, input logic [15:0] ld_val);
    logic       rdy;
    int         slot;
    int         c;
    logic [3:0] nib;
    logic [3:0] ee;
    logic [6:0] es;
    logic       mbit;
    rdy        = rdy0;
    blank_mask = mask;
    for (int k = 0; k < ND * SD; k++) begin
      @(negedge clk);
      slot = k / SD;
      c    = k % SD;
      nib  = 4'(val >> (slot * 4));
      mbit = |(mask & (4'b0001 << slot));
      ee   = (c >= BC) ? (4'b0001 << slot) : 4'b0000;
      es   = (c >= BC && !mbit) ? seg_tab[nib] : 7'b0;
      if (ld_at >= 0 && k == ld_at + 1) rdy = 1'b0;
      chk("dig_en", 32'(dig_en), 32'(ee));
      chk("seg", 32'(seg), 32'(es));
      chk("cur_digit", 32'(cur_digit), 32'(slot));
      chk("frame_done", 32'(frame_done), (k == 0) ? 32'(fd0) : 32'd0);
      chk("load_ready", 32'(lif.load_ready), 32'(rdy));
      lif.load_valid = (k == ld_at);
      if (k == ld_at) lif.load_data = ld_val;
    end
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;

    @(negedge clk);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_dig_en", 32'(dig_en), 32'd0);
    chk("rst_cur_digit", 32'(cur_digit), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_load_ready", 32'(lif.load_ready), 32'd1);
    rst_n = 1'b1;

    // Load while idle: ready drops for one cycle, display stays dark.
    @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1234;
    @(negedge clk);
    chk("idle_ready_low", 32'(lif.load_ready), 32'd0);
    chk("idle_seg", 32'(seg), 32'd0);
    chk("idle_dig_en", 32'(dig_en), 32'd0);
    lif.load_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready_high", 32'(lif.load_ready), 32'd1);
    chk("idle_seg2", 32'(seg), 32'd0);
    chk("idle_dig_en2", 32'(dig_en), 32'd0);

    // Scan 0x1234, then load 0xFEDC mid-frame.
    enable = 1'b1;
    run_frame(16'h1234, 4'b0000, 1'b0, 1'b1, -1, 16'h0);
    run_frame(16'h1234, 4'b0000, 1'b1, 1'b1, 10, 16'hFEDC);
    // Load offered on the boundary cycle: old value holds one more frame.
    run_frame(16'hFEDC, 4'b0000, 1'b1, 1'b1, 31, 16'h8888);
    run_frame(16'hFEDC, 4'b0000, 1'b1, 1'b0, -1, 16'h0);
    run_frame(16'h8888, 4'b0000, 1'b1, 1'b1, -1, 16'h0);
    run_frame(16'h8888, 4'b0100, 1'b1, 1'b1, -1, 16'h0);

    // Drop enable mid-DRIVE of digit 0.
    repeat (4) @(negedge clk);
    chk("pre_dis_dig_en", 32'(dig_en), 32'h1);
    chk("pre_dis_seg", 32'(seg), 32'h7F);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_dig_en", 32'(dig_en), 32'd0);
    chk("dis_seg", 32'(seg), 32'd0);
    chk("dis_cur_digit", 32'(cur_digit), 32'd0);
    chk("dis_frame_done", 32'(frame_done), 32'd0);

    // Re-enable, park a pending word, then reset asynchronously mid-DRIVE.
    enable = 1'b1;
    @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1111;
    @(negedge clk);
    chk("pend_ready_low", 32'(lif.load_ready), 32'd0);
    lif.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_dig_en", 32'(dig_en), 32'h1);
    chk("pre_rst_seg", 32'(seg), 32'h7F);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'd0);
    chk("arst_dig_en", 32'(dig_en), 32'd0);
    chk("arst_cur_digit", 32'(cur_digit), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_load_ready", 32'(lif.load_ready), 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    run_frame(16'h0000, 4'b0000, 1'b0, 1'b1, -1, 16'h0);
    run_frame(16'h0000, 4'b0000, 1'b1, 1'b1, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
